// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: state encodings and
// the default bubble payload built from the NOP instruction encoding.
package id_ex_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [31:0] INS_NOP   = 32'h0000_0013;
    localparam logic [63:0] ZERO_WORD = 64'h0000_0000_0000_0000;

    // Upper half stays zero so the NOP occupies the instruction field only.
    localparam logic [63:0] BUBBLE_DEFAULT = {ZERO_WORD[63:32], INS_NOP};

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX stage register: valid/ready handshake with a 2-entry skid buffer,
// flush/stall controls, early load-address request and a bubble counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(BUBBLE_DEFAULT),
    parameter int                ADDR_W     = 32,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              pre_req_i,
    input  logic [ADDR_W-1:0] pre_base_i,
    input  logic [ADDR_W-1:0] pre_off_i,
    output logic              pre_req_o,
    output logic [ADDR_W-1:0] pre_addr_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic accept;
    logic take;

    // Offset is a sign-extended immediate; modular addition covers both signs.
    function automatic logic [ADDR_W-1:0] ea_calc(input logic [ADDR_W-1:0] base,
                                                  input logic signed [ADDR_W-1:0] off);
        return base + $unsigned(off);
    endfunction

    // rst_n gates accept so no early request escapes while reset is held.
    assign accept = rst_n & in_valid_i & in_ready_q & ~stall_i & ~flush_i;
    assign take   = out_valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Skid contents are only meaningful in ST_FULL, so they carry no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

    assign pre_req_o  = pre_req_i & accept;
    assign pre_addr_o = pre_req_o ? ea_calc(pre_base_i, pre_off_i) : '0;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (~out_valid_q),
        .clr  (cnt_clr_i),
        .cnt_o(bubble_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed-vector bench for id_ex_pipe: per-cycle table plus hand sequences
// for the bubble counter and a mid-stream asynchronous reset.
module tb_id_ex_pipe;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;
    localparam int NVEC = 29;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic              flush_i;
    logic              stall_i;
    logic              pre_req_i;
    logic [ADDR_W-1:0] pre_base_i;
    logic [ADDR_W-1:0] pre_off_i;
    logic              pre_req_o;
    logic [ADDR_W-1:0] pre_addr_o;
    logic              cnt_clr_i;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .pre_req_i   (pre_req_i),
        .pre_base_i  (pre_base_i),
        .pre_off_i   (pre_off_i),
        .pre_req_o   (pre_req_o),
        .pre_addr_o  (pre_addr_o),
        .cnt_clr_i   (cnt_clr_i),
        .bubble_cnt_o(bubble_cnt_o)
    );

    typedef struct packed {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        st;
        logic        pr;
        logic [31:0] base;
        logic [31:0] off;
        logic        e_rdy;
        logic        e_ov;
        logic [63:0] e_data;
        logic        e_pr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(logic iv, logic [63:0] d, logic ordy, logic fl, logic st,
                                logic pr, logic [31:0] base, logic [31:0] off,
                                logic e_rdy, logic e_ov, logic [63:0] e_data,
                                logic e_pr, logic [31:0] e_addr);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.st = st;
        v.pr = pr; v.base = base; v.off = off;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data;
        v.e_pr = e_pr; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        stall_i     = 1'b0;
        pre_req_i   = 1'b0;
        pre_base_i  = '0;
        pre_off_i   = '0;
        cnt_clr_i   = 1'b0;
    endtask

    initial begin
        // Columns: iv, data, out_ready, flush, stall, pre_req, base, off | rdy, ovalid, odata, pre_req_o, pre_addr_o
        vecs[0]  = mk(0, 64'h0,  0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[1]  = mk(1, 64'h1,  1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[2]  = mk(1, 64'h2,  1, 0, 0, 0, 0, 0,  1, 1, 64'h1,   0, 0);
        vecs[3]  = mk(1, 64'h3,  1, 0, 0, 0, 0, 0,  1, 1, 64'h2,   0, 0);
        vecs[4]  = mk(1, 64'h4,  1, 0, 0, 0, 0, 0,  1, 1, 64'h3,   0, 0);
        vecs[5]  = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 1, 64'h4,   0, 0);
        vecs[6]  = mk(0, 64'h0,  0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[7]  = mk(1, 64'hA,  0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[8]  = mk(1, 64'hB,  0, 0, 0, 0, 0, 0,  1, 1, 64'hA,   0, 0);
        vecs[9]  = mk(1, 64'hC,  0, 0, 0, 0, 0, 0,  0, 1, 64'hA,   0, 0);
        vecs[10] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  0, 1, 64'hA,   0, 0);
        vecs[11] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 1, 64'hB,   0, 0);
        vecs[12] = mk(0, 64'h0,  0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[13] = mk(1, 64'h21, 0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[14] = mk(1, 64'h22, 0, 0, 0, 0, 0, 0,  1, 1, 64'h21,  0, 0);
        vecs[15] = mk(1, 64'h23, 0, 1, 0, 0, 0, 0,  0, 1, 64'h21,  0, 0);
        vecs[16] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[17] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[18] = mk(1, 64'h31, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'h20,
                      1, 0, BUB, 1, 32'h10);
        vecs[19] = mk(1, 64'h32, 1, 0, 1, 1, 32'hFFFF_FFF0, 32'h20,
                      1, 1, 64'h31, 0, 0);
        vecs[20] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[21] = mk(1, 64'h41, 0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[22] = mk(1, 64'h42, 0, 0, 0, 0, 0, 0,  1, 1, 64'h41,  0, 0);
        vecs[23] = mk(1, 64'h43, 1, 0, 1, 0, 0, 0,  0, 1, 64'h41,  0, 0);
        vecs[24] = mk(1, 64'h44, 1, 0, 1, 0, 0, 0,  1, 1, 64'h42,  0, 0);
        vecs[25] = mk(0, 64'h0,  1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[26] = mk(1, 64'h51, 1, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);
        vecs[27] = mk(1, 64'h52, 1, 1, 0, 1, 32'h100, 32'h4,
                      1, 1, 64'h51, 0, 0);
        vecs[28] = mk(0, 64'h0,  0, 0, 0, 0, 0, 0,  1, 0, BUB,     0, 0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_in_ready",   {63'b0, in_ready_o},  64'h1);
        chk("rst_out_valid",  {63'b0, out_valid_o}, 64'h0);
        chk("rst_out_data",   out_data_o,           BUB);
        chk("rst_bubble_cnt", {60'b0, bubble_cnt_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid_i  = vecs[i].iv;
            in_data_i   = vecs[i].d;
            out_ready_i = vecs[i].ordy;
            flush_i     = vecs[i].fl;
            stall_i     = vecs[i].st;
            pre_req_i   = vecs[i].pr;
            pre_base_i  = vecs[i].base;
            pre_off_i   = vecs[i].off;
            #4;
            chk($sformatf("v%0d_in_ready", i),  {63'b0, in_ready_o},  {63'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d_out_valid", i), {63'b0, out_valid_o}, {63'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_out_data", i),  out_data_o,           vecs[i].e_data);
            chk($sformatf("v%0d_pre_req", i),   {63'b0, pre_req_o},   {63'b0, vecs[i].e_pr});
            chk($sformatf("v%0d_pre_addr", i),  {32'b0, pre_addr_o},  {32'b0, vecs[i].e_addr});
        end

        // Bubble counter: clear, resume, saturate, clear again.
        @(negedge clk);
        idle_inputs();
        cnt_clr_i = 1'b1;
        @(negedge clk);
        cnt_clr_i = 1'b0;
        #4;
        chk("cnt_after_clr", {60'b0, bubble_cnt_o}, 64'h0);
        @(negedge clk);
        #4;
        chk("cnt_resume", {60'b0, bubble_cnt_o}, 64'h1);
        repeat (20) @(negedge clk);
        #4;
        chk("cnt_saturate", {60'b0, bubble_cnt_o}, 64'hF);
        @(negedge clk);
        cnt_clr_i = 1'b1;
        @(negedge clk);
        cnt_clr_i = 1'b0;
        #4;
        chk("cnt_clr_from_sat", {60'b0, bubble_cnt_o}, 64'h0);
        @(negedge clk);
        #4;
        chk("cnt_resume2", {60'b0, bubble_cnt_o}, 64'h1);

        // Mid-stream reset: load a beat, then assert reset with a load pending.
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = 64'h61;
        @(negedge clk);
        #4;
        chk("pre_rst_valid", {63'b0, out_valid_o}, 64'h1);
        @(negedge clk);
        pre_req_i  = 1'b1;
        pre_base_i = 32'h1000;
        pre_off_i  = 32'h8;
        rst_n      = 1'b0;
        #1;
        chk("arst_in_ready",  {63'b0, in_ready_o},   64'h1);
        chk("arst_out_valid", {63'b0, out_valid_o},  64'h0);
        chk("arst_out_data",  out_data_o,            BUB);
        chk("arst_cnt",       {60'b0, bubble_cnt_o}, 64'h0);
        chk("arst_pre_req",   {63'b0, pre_req_o},    64'h0);
        chk("arst_pre_addr",  {32'b0, pre_addr_o},   64'h0);
        repeat (3) @(negedge clk);
        #4;
        chk("arst_hold_valid", {63'b0, out_valid_o}, 64'h0);
        chk("arst_hold_data",  out_data_o,           BUB);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        #4;
        chk("post_rst_valid", {63'b0, out_valid_o},  64'h0);
        chk("post_rst_cnt",   {60'b0, bubble_cnt_o}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
